imem_uart_loader: RTL and testbench
===================================

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning instruction-memory capacity in 32-bit words.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  UART serial input, idle high, asynchronous to clk.
REQ-006 SHALL have port imem_we  output  1  instruction-memory write strobe, one-cycle pulse.
REQ-007 SHALL have port imem_addr  output  32  byte address of the word being written.
REQ-008 SHALL have port imem_wdata  output  32  word being written.
REQ-009 SHALL have port cpu_reset  output  1  hold-reset for the pipelined core; high until the load completes.
REQ-010 SHALL have port load_done  output  1  high when the image is fully loaded.
REQ-011 SHALL have port load_err  output  1  sticky error flag.

Function
REQ-012 SHALL pass rx through a 2-flop synchroniser before any use; the synchronised value SHALL reset to 1.
REQ-013 RX SHALL detect a start bit on a synchronised 1->0 transition, re-sample at CLKS_PER_BIT/2, and return to idle without a byte if the line is high again (glitch).
REQ-014 RX SHALL sample 8 data bits LSB-first, each CLKS_PER_BIT cycles after the previous sample, then sample the stop bit after another CLKS_PER_BIT cycles.
REQ-015 RX SHALL produce a one-cycle byte-valid in the cycle after the stop-bit sample if the stop bit is 1; a 0 stop bit is a framing error and produces no byte.
REQ-016 Loader FSM states: LEN_LO, LEN_HI, DATA, DONE, ERROR; the reset state SHALL be LEN_LO.
REQ-017 LEN_LO: first byte becomes N[7:0] -> LEN_HI; LEN_HI: second byte becomes N[15:8].
REQ-018 On leaving LEN_HI, N=0 -> DONE; N>DEPTH_WORDS -> ERROR; otherwise -> DATA with word index 0 and byte index 0.
REQ-019 DATA: bytes SHALL assemble little-endian (first byte into wdata[7:0], fourth into [31:24]).
REQ-020 On the fourth byte, imem_we SHALL pulse high for exactly one cycle, with imem_addr = word_index*4 and imem_wdata = assembled word valid in the same cycle.
REQ-021 imem_addr and imem_wdata SHALL hold their last values between writes; imem_we SHALL be 0 in every other cycle.
REQ-022 After writing word index N-1, the FSM SHALL enter DONE in the cycle after the write pulse.
REQ-023 DONE: cpu_reset=0, load_done=1; all further rx bytes SHALL be ignored and no writes issued.
REQ-024 A framing error in LEN_LO, LEN_HI or DATA SHALL move the FSM to ERROR; in DONE it SHALL be ignored.
REQ-025 ERROR: load_err=1, cpu_reset=1, load_done=0, no writes; exit only via reset.
REQ-026 cpu_reset SHALL be 1 in every state other than DONE, and SHALL deassert in the same cycle load_done asserts.

Reset
REQ-027 Asserting reset at any time, including mid-byte or mid-word, SHALL immediately force: FSM=LEN_LO, RX idle, counters=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_err=0.
REQ-028 A partially received word at reset SHALL be discarded and never written.

Verification (bench uses CLKS_PER_BIT=4, DEPTH_WORDS=8)
REQ-029 Bytes 02 00 13 05 A0 00 6F 00 00 00 -> writes (addr 0x0, data 0x00A00513) and (addr 0x4, data 0x0000006F), one imem_we pulse each; then load_done=1, cpu_reset=0.
REQ-030 Bytes 00 00 -> no writes; load_done=1, cpu_reset=0 after second byte; later byte FF -> no effect.
REQ-031 Bytes 09 00 (N=9 > 8) -> load_err=1, cpu_reset=1, no writes; further bytes ignored until reset.
REQ-032 Byte with stop bit driven 0 during DATA -> load_err=1, no write of the partial word; reset -> all outputs return to REQ-027 values.
REQ-033 rx low pulse of 1 cycle while idle -> no byte, FSM unchanged; reset asserted after 2 of 4 data bytes, then full image 01 00 EF BE AD DE -> single write addr 0x0, data 0xDEADBEEF.

Source files
------------

// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a length-prefixed little-endian instruction image over rx
// and writes it word by word into instruction memory while holding the core in reset.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_WORDS  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} ld_state_t;

    // ------------------------------------------------------------------ synchroniser
    logic rx_meta, rx_sync, rx_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------ UART receiver
    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic        rx_valid, rx_valid_nxt;
    logic        rx_ferr, rx_ferr_nxt;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 16'd1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_valid_nxt = 1'b0;
        rx_ferr_nxt  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = 16'd0;
                if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                // Mid-start-bit re-check rejects short glitches on the line.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = 16'd0;
                    rx_bit_nxt   = 3'd0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = 16'd0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = 16'd0;
                    rx_valid_nxt = rx_sync;
                    rx_ferr_nxt  = !rx_sync;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_valid <= rx_valid_nxt;
            rx_ferr  <= rx_ferr_nxt;
        end
    end

    // ------------------------------------------------------------------ loader FSM
    ld_state_t   state, state_nxt;
    logic [15:0] len, len_nxt, len_cand;
    logic [15:0] word_idx, word_idx_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [23:0] wbuf, wbuf_nxt;
    logic        we_nxt;
    logic [31:0] addr_nxt, wdata_nxt;

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        len_cand     = {rx_shift, len[7:0]};
        word_idx_nxt = word_idx;
        byte_idx_nxt = byte_idx;
        wbuf_nxt     = wbuf;
        we_nxt       = 1'b0;
        addr_nxt     = imem_addr;
        wdata_nxt    = imem_wdata;
        cpu_reset    = 1'b1;
        load_done    = 1'b0;
        load_err     = 1'b0;
        case (state)
            LEN_LO: begin
                if (rx_ferr) begin
                    state_nxt = ERROR;
                end else if (rx_valid) begin
                    len_nxt[7:0] = rx_shift;
                    state_nxt    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_ferr) begin
                    state_nxt = ERROR;
                end else if (rx_valid) begin
                    len_nxt = len_cand;
                    if (len_cand == 16'd0) begin
                        state_nxt = DONE;
                    end else if (32'(len_cand) > DEPTH_LIM) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt    = DATA;
                        word_idx_nxt = 16'd0;
                        byte_idx_nxt = 2'd0;
                    end
                end
            end
            DATA: begin
                if (rx_ferr) begin
                    state_nxt = ERROR;
                end else if (imem_we && word_idx == len) begin
                    // word_idx already counts the word just written.
                    state_nxt = DONE;
                end else if (rx_valid) begin
                    byte_idx_nxt = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: wbuf_nxt[7:0]   = rx_shift;
                        2'd1: wbuf_nxt[15:8]  = rx_shift;
                        2'd2: wbuf_nxt[23:16] = rx_shift;
                        default: begin
                            we_nxt       = 1'b1;
                            addr_nxt     = {14'd0, word_idx, 2'b00};
                            wdata_nxt    = {rx_shift, wbuf};
                            word_idx_nxt = word_idx + 16'd1;
                        end
                    endcase
                end
            end
            DONE: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
            end
            ERROR: load_err = 1'b1;
            default: state_nxt = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LEN_LO;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            wbuf       <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            word_idx   <= word_idx_nxt;
            byte_idx   <= byte_idx_nxt;
            wbuf       <= wbuf_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomised scoreboard bench for imem_uart_loader: an image-level model predicts the
// memory writes and final status; a monitor pops expected writes on every imem_we pulse.
module tb_imem_uart_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_reset, load_done, load_err;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] hold_addr, hold_data;
    logic        we_prev;
    logic [7:0]  img[$];
    int          ferr_at;
    logic        exp_done, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write; between pulses
    // address and data must hold the last written values.
    always @(negedge clk) begin
        if (reset) begin
            hold_addr = 32'd0;
            hold_data = 32'd0;
            we_prev   = 1'b0;
        end else begin
            if (imem_we) begin
                check("we_single_cycle", {31'd0, we_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%h data=%h required=no write",
                             imem_addr, imem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", imem_addr, e.addr);
                    check("write_data", imem_wdata, e.data);
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
            end else begin
                check("hold_addr", imem_addr, hold_addr);
                check("hold_data", imem_wdata, hold_data);
            end
            we_prev = imem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic check_status(input string name);
        check({name, "_load_done"}, {31'd0, load_done}, {31'd0, exp_done});
        check({name, "_load_err"},  {31'd0, load_err},  {31'd0, exp_err});
        check({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        #1;
        check("rst_we",        {31'd0, imem_we},   32'd0);
        check("rst_addr",      imem_addr,          32'd0);
        check("rst_wdata",     imem_wdata,         32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err",  {31'd0, load_err},  32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Image-level model: length prefix, bounds, completed words, first framing error.
    task automatic model_image();
        int e, n, avail, full;
        e = (ferr_at < 0) ? img.size() : ferr_at;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (e < 2) begin
            exp_err = (e < img.size());
            return;
        end
        n = int'(img[0]) + 256 * int'(img[1]);
        if (n == 0) begin
            exp_done = 1'b1;
        end else if (n > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            avail = (e < img.size()) ? e : img.size();
            full  = (avail - 2) / 4;
            if (full > n) full = n;
            for (int w = 0; w < full; w++) begin
                wr_t x;
                x.addr = 32'(4 * w);
                x.data = {img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]};
                exp_q.push_back(x);
            end
            if (full == n) exp_done = 1'b1;
            else if (e < img.size()) exp_err = 1'b1;
        end
    endtask

    task automatic run_image(input string name);
        model_image();
        for (int i = 0; i < img.size(); i++) send_byte(img[i], (i == ferr_at) ? 1'b0 : 1'b1);
        repeat (10) @(negedge clk);
        check({name, "_pending_writes"}, exp_q.size(), 32'd0);
        check_status(name);
    endtask

    initial begin
        exp_done = 1'b0;
        exp_err  = 1'b0;
        ferr_at  = -1;
        repeat (3) @(negedge clk);
        do_reset();
        check_status("after_reset");

        // Two-word program.
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        ferr_at = -1;
        run_image("two_words");

        // Empty image, then traffic in DONE (good byte and a framed-bad byte) is ignored.
        do_reset();
        img = '{8'h00, 8'h00};
        run_image("empty");
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        check_status("empty_after_extra");

        // Length one past capacity, trailing bytes ignored.
        do_reset();
        img = '{8'h09, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_image("too_long");

        // Length exactly at capacity is accepted.
        do_reset();
        img = '{8'h08, 8'h00};
        for (int i = 0; i < 32; i++) img.push_back(8'($urandom));
        run_image("full_depth");

        // Framing error mid-word in DATA: partial word never written.
        do_reset();
        img = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        ferr_at = 8;
        run_image("ferr_data");
        do_reset();
        check_status("ferr_reset");

        // One-cycle glitch while idle produces no byte.
        ferr_at = -1;
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (20) @(negedge clk);
        check_status("glitch");

        // Reset after two data bytes, then a clean image.
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        run_image("partial");
        do_reset();
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_image("deadbeef");

        // Randomised images, lengths possibly out of range, occasional framing error.
        for (int r = 0; r < 8; r++) begin
            int n;
            do_reset();
            n = $urandom_range(0, 10);
            img = '{8'(n), 8'h00};
            for (int i = 0; i < 4 * ((n > DEPTH) ? 1 : n); i++) img.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) img.push_back(8'($urandom));
            ferr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
            run_image($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
